// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      DBG_IDLE = 1'b0,
      DBG_RESP = 1'b1
   } dbg_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves all core write ports against one address: reports whether any
// enabled port targets it and, if so, the data of the highest-index port.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_AW,
   parameter int NUM_WR = 1
) (
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]        addr,
   output logic                     hit,
   output logic [DATA_W-1:0]        data
);

   // Ascending scan: a later (higher-index) match overrides earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
            hit  = 1'b1;
            data = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with combinational read bypass, prioritised core
// writes, optional hardwired zero entry and a valid/ready debug port.
//
// Debug FSM:
//   state    | meaning
//   DBG_IDLE | waiting for a debug request; ready unless a core write is active
//   DBG_RESP | response held on dbg_rsp_*; waits for dbg_rsp_ready
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = XLEN,
   parameter int ADDR_W   = REG_AW,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     dbg_req_valid,
   output logic                     dbg_req_ready,
   input  logic                     dbg_req_we,
   input  logic [ADDR_W-1:0]        dbg_req_addr,
   input  logic [DATA_W-1:0]        dbg_req_wdata,
   output logic                     dbg_rsp_valid,
   output logic [DATA_W-1:0]        dbg_rsp_rdata,
   input  logic                     dbg_rsp_ready
);

   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   if (NUM_RD < 1 || NUM_WR < 1) begin : g_param_err
      $error("register_file_mp: NUM_RD and NUM_WR must both be at least 1");
   end

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [DEPTH-1:0]        ent_hit;
   logic [DEPTH*DATA_W-1:0] ent_data;

   dbg_state_e        state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] dbg_rd_val;
   logic              dbg_wr_fire;

   // Read ports: zero entry first, then same-cycle bypass, then storage.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              byp_hit;
      logic [DATA_W-1:0] byp_data;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      regfile_wr_arb #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_arb (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .addr    (ra),
         .hit     (byp_hit),
         .data    (byp_data)
      );

      assign rd_data[k*DATA_W +: DATA_W] = (ZR && (ra == '0)) ? '0 :
                                           (BP && byp_hit)    ? byp_data :
                                                                mem[ra];
   end

   // One arbiter per entry picks the winning core write for that entry.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      regfile_wr_arb #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_arb (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .addr    (ADDR_W'(i)),
         .hit     (ent_hit[i]),
         .data    (ent_data[i*DATA_W +: DATA_W])
      );
   end

   // Debug reads see storage only; core writes cannot coincide with them.
   assign dbg_rd_val  = (ZR && (dbg_req_addr == '0)) ? '0 : mem[dbg_req_addr];
   assign dbg_wr_fire = (state_q == DBG_IDLE) && dbg_req_valid && dbg_req_ready && dbg_req_we;

   // Storage update; core and debug writes are mutually exclusive by ready gating.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(ZR && (i == 0))) begin
               if (ent_hit[i]) begin
                  mem[i] <= ent_data[i*DATA_W +: DATA_W];
               end else if (dbg_wr_fire && (dbg_req_addr == ADDR_W'(i))) begin
                  mem[i] <= dbg_req_wdata;
               end
            end
         end
      end
   end

   // Debug FSM next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      rdata_d       = rdata_q;
      dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b0;
      case (state_q)
         DBG_IDLE: begin
            dbg_req_ready = rst_n & ~(|wr_en);
            if (dbg_req_valid && dbg_req_ready) begin
               state_d = DBG_RESP;
               rdata_d = dbg_req_we ? '0 : dbg_rd_val;
            end
         end
         DBG_RESP: begin
            dbg_rsp_valid = 1'b1;
            if (dbg_rsp_ready) begin
               state_d = DBG_IDLE;
            end
         end
      endcase
   end

   // Debug FSM state and captured response data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DBG_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   assign dbg_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: unit 0 = 2R/2W, zero reg, bypass;
// unit 1 = 1R/1W, no zero reg, no bypass. Both checked every cycle
// against an array-based model, plus directed literal checks.
module tb_register_file_mp;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  wen  [2];
   logic [4:0]  wadr [2][2];
   logic [31:0] wdat [2][2];
   logic [4:0]  radr [2][2];
   logic        dv [2], dwe [2], drr [2];
   logic [4:0]  dad [2];
   logic [31:0] dwd [2];

   logic [63:0] a_rd_data;
   logic [31:0] b_rd_data;
   logic [31:0] rdat [2][2];
   logic        rdy [2], rv [2];
   logic [31:0] rrd [2];

   assign rdat[0][0] = a_rd_data[31:0];
   assign rdat[0][1] = a_rd_data[63:32];
   assign rdat[1][0] = b_rd_data;
   assign rdat[1][1] = '0;

   register_file_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
   ) u_dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_addr       ({radr[0][1], radr[0][0]}),
      .rd_data       (a_rd_data),
      .wr_en         (wen[0]),
      .wr_addr       ({wadr[0][1], wadr[0][0]}),
      .wr_data       ({wdat[0][1], wdat[0][0]}),
      .dbg_req_valid (dv[0]),
      .dbg_req_ready (rdy[0]),
      .dbg_req_we    (dwe[0]),
      .dbg_req_addr  (dad[0]),
      .dbg_req_wdata (dwd[0]),
      .dbg_rsp_valid (rv[0]),
      .dbg_rsp_rdata (rrd[0]),
      .dbg_rsp_ready (drr[0])
   );

   register_file_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
   ) u_dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_addr       (radr[1][0]),
      .rd_data       (b_rd_data),
      .wr_en         (wen[1][0]),
      .wr_addr       (wadr[1][0]),
      .wr_data       (wdat[1][0]),
      .dbg_req_valid (dv[1]),
      .dbg_req_ready (rdy[1]),
      .dbg_req_we    (dwe[1]),
      .dbg_req_addr  (dad[1]),
      .dbg_req_wdata (dwd[1]),
      .dbg_rsp_valid (rv[1]),
      .dbg_rsp_rdata (rrd[1]),
      .dbg_rsp_ready (drr[1])
   );

   int total = 0;
   int bad = 0;

   // ---------------- model ----------------
   logic [31:0] mm [2][32];
   bit          pend [2];
   logic [31:0] prd [2];
   bit          init_done = 1'b0;

   function automatic int nports(int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic bit has_zero(int u);
      return (u == 0);
   endfunction

   function automatic bit any_wr(int u);
      bit r = 1'b0;
      for (int j = 0; j < nports(u); j++) if (wen[u][j]) r = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] exp_read(int u, logic [4:0] a);
      logic [31:0] v = mm[u][a];
      if (has_zero(u) && a == 5'd0) return 32'd0;
      if (u == 0) begin
         for (int j = 0; j < nports(u); j++)
            if (wen[u][j] && wadr[u][j] == a) v = wdat[u][j];
      end
      return v;
   endfunction

   task automatic model_step();
      bit fire;
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 32; a++) mm[u][a] = 32'd0;
            pend[u] = 1'b0;
            prd[u]  = 32'd0;
         end
         init_done = 1'b1;
      end else begin
         for (int u = 0; u < 2; u++) begin
            fire = dv[u] && !pend[u] && !any_wr(u);
            if (pend[u]) begin
               if (drr[u]) pend[u] = 1'b0;
            end else if (fire) begin
               pend[u] = 1'b1;
               if (dwe[u]) prd[u] = 32'd0;
               else prd[u] = (has_zero(u) && dad[u] == 5'd0) ? 32'd0 : mm[u][dad[u]];
            end
            for (int j = 0; j < nports(u); j++)
               if (wen[u][j] && !(has_zero(u) && wadr[u][j] == 5'd0))
                  mm[u][wadr[u][j]] = wdat[u][j];
            if (fire && dwe[u] && !(has_zero(u) && dad[u] == 5'd0))
               mm[u][dad[u]] = dwd[u];
         end
      end
   endtask

   task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s unit%0d t=%0t got=%h want=%h", nm, u, $time, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare process: every negedge once the model has seen a reset.
   initial forever begin
      @(negedge clk);
      if (init_done) begin
         for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < nports(u); k++)
               chk("rd_data", u, rdat[u][k], exp_read(u, radr[u][k]));
            chk("req_ready", u, 32'(rdy[u]), 32'(rst_n && !pend[u] && !any_wr(u)));
            chk("rsp_valid", u, 32'(rv[u]), 32'(pend[u]));
            if (pend[u]) chk("rsp_rdata", u, rrd[u], prd[u]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int u = 0; u < 2; u++) begin
         wen[u] = 2'b00;
         dv[u] = 1'b0; dwe[u] = 1'b0; drr[u] = 1'b0;
         dad[u] = 5'd0; dwd[u] = 32'd0;
         for (int j = 0; j < 2; j++) begin
            wadr[u][j] = 5'd0; wdat[u][j] = 32'd0; radr[u][j] = 5'd0;
         end
      end
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic rnd_inputs();
      for (int u = 0; u < 2; u++) begin
         wen[u] = (u == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) wen[u] = 2'b00;
         for (int j = 0; j < 2; j++) begin
            wadr[u][j] = rnd_addr();
            wdat[u][j] = $urandom;
            radr[u][j] = rnd_addr();
         end
         dv[u]  = 1'($urandom_range(0, 1));
         dwe[u] = 1'($urandom_range(0, 1));
         dad[u] = rnd_addr();
         dwd[u] = $urandom;
         drr[u] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (20) begin
         rnd_inputs();
         for (int u = 0; u < 2; u++) begin dv[u] = 1'b0; drr[u] = 1'b1; end
         for (int u = 0; u < 2; u++) for (int j = 0; j < 2; j++) wadr[u][j] = 5'($urandom_range(0, 31));
         tick();
      end

      // reset with populated contents
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #2;
      chk("rst_rsp_valid", 0, 32'(rv[0]), 32'd0);
      chk("rst_rsp_rdata", 0, rrd[0], 32'd0);
      for (int i = 0; i < 4; i++) begin
         radr[0][0] = 5'(i * 9 + 1);
         radr[1][0] = 5'(i * 9 + 1);
         #1;
         chk("rst_rd", 0, rdat[0][0], 32'd0);
         chk("rst_rd", 1, rdat[1][0], 32'd0);
      end

      // debug read of x5 after reset
      tick();
      dv[0] = 1'b1; dwe[0] = 1'b0; dad[0] = 5'd5;
      tick();
      dv[0] = 1'b0;
      #2;
      chk("dbg_rd_x5_valid", 0, 32'(rv[0]), 32'd1);
      chk("dbg_rd_x5_data", 0, rrd[0], 32'd0);
      drr[0] = 1'b1;
      tick();
      drr[0] = 1'b0;
      #2;
      chk("dbg_rd_x5_done", 0, 32'(rv[0]), 32'd0);

      // bypass vs no bypass
      wen[0] = 2'b01; wadr[0][0] = 5'd7; wdat[0][0] = 32'hDEADBEEF; radr[0][0] = 5'd7;
      wen[1] = 2'b01; wadr[1][0] = 5'd7; wdat[1][0] = 32'hDEADBEEF; radr[1][0] = 5'd7;
      #2;
      chk("bypass_same", 0, rdat[0][0], 32'hDEADBEEF);
      chk("nobypass_same", 1, rdat[1][0], 32'd0);
      tick();
      wen[0] = 2'b00; wen[1] = 2'b00;
      #2;
      chk("bypass_next", 0, rdat[0][0], 32'hDEADBEEF);
      chk("nobypass_next", 1, rdat[1][0], 32'hDEADBEEF);

      // write conflict on address 3
      wen[0] = 2'b11; wadr[0][0] = 5'd3; wadr[0][1] = 5'd3;
      wdat[0][0] = 32'h11; wdat[0][1] = 32'h22; radr[0][1] = 5'd3;
      #2;
      chk("conflict_bypass", 0, rdat[0][1], 32'h22);
      tick();
      wen[0] = 2'b00;
      #2;
      chk("conflict_stored", 0, rdat[0][1], 32'h22);

      // zero register, core path
      wen[0] = 2'b01; wadr[0][0] = 5'd0; wdat[0][0] = 32'hFFFFFFFF; radr[0][0] = 5'd0;
      wen[1] = 2'b01; wadr[1][0] = 5'd0; wdat[1][0] = 32'hFFFFFFFF; radr[1][0] = 5'd0;
      #2;
      chk("zero_bypass", 0, rdat[0][0], 32'd0);
      tick();
      wen[0] = 2'b00; wen[1] = 2'b00;
      #2;
      chk("zero_stored", 0, rdat[0][0], 32'd0);
      chk("nozero_stored", 1, rdat[1][0], 32'hFFFFFFFF);

      // zero register, debug path
      for (int u = 0; u < 2; u++) begin dv[u] = 1'b1; dwe[u] = 1'b1; dad[u] = 5'd0; dwd[u] = 32'hFFFFFFFF; end
      tick();
      dv[0] = 1'b0; dv[1] = 1'b0;
      #2;
      chk("dbg_wr_rsp_rdata", 0, rrd[0], 32'd0);
      chk("dbg_wr_rsp_rdata", 1, rrd[1], 32'd0);
      drr[0] = 1'b1; drr[1] = 1'b1;
      tick();
      drr[0] = 1'b0; drr[1] = 1'b0;
      for (int u = 0; u < 2; u++) begin dv[u] = 1'b1; dwe[u] = 1'b0; dad[u] = 5'd0; end
      tick();
      dv[0] = 1'b0; dv[1] = 1'b0;
      #2;
      chk("zero_dbg_rd", 0, rrd[0], 32'd0);
      chk("nozero_dbg_rd", 1, rrd[1], 32'hFFFFFFFF);
      drr[0] = 1'b1; drr[1] = 1'b1;
      tick();
      drr[0] = 1'b0; drr[1] = 1'b0;

      // debug handshake stalled by core writes
      wen[0] = 2'b01; wadr[0][0] = 5'd9; wdat[0][0] = 32'h1234;
      tick();
      wadr[0][0] = 5'd20; wdat[0][0] = 32'hCAFE0000;
      dv[0] = 1'b1; dwe[0] = 1'b0; dad[0] = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("hs_stall_ready", 0, 32'(rdy[0]), 32'd0);
         tick();
      end
      wen[0] = 2'b00;
      #2;
      chk("hs_ready", 0, 32'(rdy[0]), 32'd1);
      tick();
      dv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("hs_hold_valid", 0, 32'(rv[0]), 32'd1);
         chk("hs_hold_rdata", 0, rrd[0], 32'h1234);
         chk("hs_hold_ready", 0, 32'(rdy[0]), 32'd0);
         tick();
      end
      drr[0] = 1'b1;
      tick();
      drr[0] = 1'b0;
      #2;
      chk("hs_consumed_valid", 0, 32'(rv[0]), 32'd0);
      chk("hs_consumed_ready", 0, 32'(rdy[0]), 32'd1);

      // reset while a response is pending
      dv[0] = 1'b1; dwe[0] = 1'b0; dad[0] = 5'd9;
      tick();
      dv[0] = 1'b0;
      #2;
      chk("mid_rsp_valid", 0, 32'(rv[0]), 32'd1);
      rst_n = 1'b0;
      tick();
      #2;
      chk("mid_rst_valid", 0, 32'(rv[0]), 32'd0);
      chk("mid_rst_ready", 0, 32'(rdy[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 0, 32'(rdy[0]), 32'd1);
      dv[0] = 1'b1; dwe[0] = 1'b0; dad[0] = 5'd9;
      tick();
      dv[0] = 1'b0;
      #2;
      chk("post_rst_valid", 0, 32'(rv[0]), 32'd1);
      chk("post_rst_rdata", 0, rrd[0], 32'd0);
      drr[0] = 1'b1;
      tick();

      // randomized traffic against the model
      repeat (3000) begin
         rnd_inputs();
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst_n = 1'b1;
      idle_inputs();
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
